// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared fetch FSM state type and default address/instruction widths.
package cpu8_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM (IDLE/REQ/WAIT/HOLD) driving a fixed-latency RAM.
// Optional FETCH_PERF_CNT_EN adds a saturating accepted-instruction counter fetch_cnt.
module fetch_ctrl #(
    parameter int ADDR_W   = cpu8_pkg::ADDR_W,
    parameter int DATA_W   = cpu8_pkg::DATA_W,
    parameter int RAM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              er,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);
    import cpu8_pkg::fetch_state_t;
    import cpu8_pkg::IDLE;
    import cpu8_pkg::REQ;
    import cpu8_pkg::WAIT;
    import cpu8_pkg::HOLD;

    localparam logic [1:0] LAST = 2'(RAM_LAT - 1);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_d;
    logic [1:0]        cnt, cnt_d;
    logic              accept;

    assign ram_addr    = pc;
    assign er          = state == REQ;
    assign instr_valid = state == HOLD;
    assign busy        = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= ADDR_W'(RESET_PC);
            instr <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            instr <= instr_d;
            cnt   <= cnt_d;
        end
    end

    // A jump overrides everything, including a same-cycle acceptance in HOLD.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr;
        cnt_d   = cnt;
        accept  = 1'b0;
        if (jump_en) begin
            pc_d    = jump_addr;
            state_d = (state == IDLE) ? IDLE : REQ;
        end else begin
            case (state)
                IDLE: state_d = run ? REQ : IDLE;
                REQ: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                WAIT: begin
                    cnt_d = cnt + 2'd1;
                    if (cnt == LAST) begin
                        instr_d = data_out;
                        state_d = HOLD;
                    end
                end
                HOLD: if (instr_ready) begin
                    accept  = 1'b1;
                    pc_d    = pc + ADDR_W'(1);
                    state_d = run ? REQ : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_cnt <= '0;
        else if (accept && fetch_cnt != 16'hFFFF)
            fetch_cnt <= fetch_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a behavioural RAM and program-counter model.
module tb_fetch_ctrl;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 24;
    localparam int RAM_LAT = 1;
    localparam int RST_PC  = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0;
    logic              jump_en = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;
    logic              instr_ready = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              er;
    logic [DATA_W-1:0] data_out = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]       fetch_cnt;
`endif

    fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .jump_en(jump_en), .jump_addr(jump_addr),
        .instr_ready(instr_ready), .ram_addr(ram_addr), .er(er), .data_out(data_out),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM: data is valid only in the cycle after the request, garbage otherwise
    logic [DATA_W-1:0] mem [256];
    always @(posedge clk) data_out <= er ? mem[ram_addr] : DATA_W'($urandom);

    // Reference model: program counter, pending fetch words, engine activity
    int                mpc = RST_PC;
    logic [DATA_W-1:0] exq[$];
    logic [DATA_W-1:0] hold_instr = '0;
    logic [DATA_W-1:0] want;
    bit                held = 0, active = 0, chk_er = 0, chk_nv = 0, exp_er = 0;
    int                cyc = 0, req_cyc = 0;
    int                mcnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpc = RST_PC; exq.delete(); held = 0; active = 0;
            chk_er = 0; chk_nv = 0; mcnt = 0;
        end else begin
            cyc++;
            if (chk_er) check("next_er", er, exp_er);
            if (chk_nv) check("valid_after_jump", instr_valid, 0);
            check("busy", busy, active);
            check("pc", pc, mpc);
            if (er) begin
                check("ram_addr", ram_addr, mpc);
                check("er_while_valid", instr_valid, 0);
                req_cyc = cyc;
                exq.push_back(mem[mpc]);
            end
            if (instr_valid) begin
                if (!held) begin
                    if (exq.size() == 0) check("unexpected_valid", instr_valid, 0);
                    else begin
                        want = exq.pop_front();
                        check("instr", instr, want);
                        check("latency", cyc - req_cyc, RAM_LAT + 1);
                    end
                    held = 1;
                    hold_instr = instr;
                end else
                    check("hold_stable", instr, hold_instr);
            end
            chk_er = 0; chk_nv = 0;
            if (jump_en) begin
                chk_nv = 1; chk_er = 1; exp_er = active;
                mpc = jump_addr; exq.delete(); held = 0;
            end else if (!active) begin
                chk_er = 1; exp_er = run; active = run;
            end else if (instr_valid && instr_ready) begin
                mpc = (mpc + 1) % 256; held = 0;
                chk_er = 1; exp_er = run; active = run;
                if (mcnt != 16'hFFFF) mcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_er();
        int n = 0;
        do begin tick(); n++; end while (!er && n < 50);
        if (!er) check("er_timeout", er, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin tick(); n++; end while (!instr_valid && n < 50);
        if (!instr_valid) check("valid_timeout", instr_valid, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_er", er, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_ram_addr", ram_addr, RST_PC);
        check("rst_instr", instr, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
        mem[0] = 24'h123456;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (3) begin tick(); check("no_req_without_run", er, 0); end
        // first fetch at address 0, accepted immediately
        run = 1'b1; instr_ready = 1'b1;
        wait_valid();
        check("first_instr", instr, 24'h123456);
        repeat (4) tick();
        // decoder stalls in HOLD
        instr_ready = 1'b0;
        wait_valid();
        repeat (5) begin tick(); check("stall_er", er, 0); check("stall_valid", instr_valid, 1); end
        instr_ready = 1'b1;
        // jump during WAIT
        wait_er();
        tick();
        jump_en = 1'b1; jump_addr = 8'h40;
        tick();
        jump_en = 1'b0;
        check("jump_req", er, 1);
        check("jump_addr", ram_addr, 8'h40);
        repeat (6) tick();
        // wrap from 0xFF
        jump_en = 1'b1; jump_addr = 8'hFF;
        tick();
        jump_en = 1'b0;
        wait_valid();
        wait_er();
        check("wrap_addr", ram_addr, 8'h00);
        // asynchronous reset during WAIT
        wait_er();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        #1 rst_n = 1'b1;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            run         = ($urandom % 8) != 0;
            jump_en     = ($urandom % 20) == 0;
            jump_addr   = ADDR_W'($urandom);
            instr_ready = ($urandom % 3) != 0;
        end
        jump_en = 1'b0; run = 1'b0; instr_ready = 1'b1;
        repeat (10) tick();
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, mcnt);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
